ahb_lite_nslave_ic: RTL and testbench
=====================================

AHB_LITE_NSLAVE_IC -- requirements
Module: ahb_lite_nslave_ic

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- NUM_SLAVES, 4, slave count, legal range 2..8.
- DATA_W, 32, data width, 32 or 64.
- SLV_BASE, {0x3000_0000, 0x2000_0000, 0x1000_0000, 0x0000_0000}, packed 32-bit base per slave; slave 0 is in the LSBs.
- SLV_MASK, {4{0xF000_0000}}, packed 32-bit decode mask per slave.
- TIMEOUT, 16, stall-cycle limit; 0 disables the watchdog.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- HCLK, in, 1, the only clock.
- HRESETn, in, 1, synchronous active-low reset.
- HADDR, in, 32, master address.
- HTRANS, in, 2, master transfer type.
- HWRITE, in, 1, master write control.
- HSIZE, in, 3, master transfer size.
- HBURST, in, 3, master burst type.
- HPROT, in, 4, master protection.
- HMASTLOCK, in, 1, master locked transfer.
- HWDATA, in, DATA_W, master write data.
- HRDATA, out, DATA_W, read data to master.
- HREADY, out, 1, bus ready to master; also broadcast to slaves.
- HRESP, out, 1, error response to master.
- hsel_s, out, NUM_SLAVES, per-slave select.
- haddr_s / htrans_s / hwrite_s / hsize_s / hburst_s / hprot_s / hmastlock_s / hwdata_s, out, same widths as the master signals, broadcast to all slaves.
- hready_s, out, 1, copy of HREADY.
- hready_resp_s, in, NUM_SLAVES, per-slave ready.
- hresp_s, in, 2*NUM_SLAVES, per-slave 2-bit response.
- hrdata_s, in, NUM_SLAVES*DATA_W, per-slave read data.
- timeout_clr, in, 1, pulse that clears timeout status.
- timeout_err, out, 1, sticky timeout flag.
- quarantine, out, NUM_SLAVES, mask of isolated slaves.

Function
REQ-003 Address/control/write-data SHALL pass combinationally from master ports to the *_s ports.
REQ-004 Decode SHALL be combinational: slave i matches when (HADDR & MASK_i) == BASE_i and quarantine[i] == 0.
- On overlapping matches, the lowest index wins; hsel_s is one-hot or all-zero.
- No match selects the internal default slave.
REQ-005 Data-phase state SHALL be captured only on cycles with HREADY=1:
- dp_sel = decoded target (slave index or default).
- dp_act = HTRANS[1].
REQ-006 When dp_sel is a real slave:
- HREADY = hready_resp_s[dp_sel].
- HRESP = OR of hresp_s[dp_sel] bits (OKAY=0; ERROR/RETRY/SPLIT=1).
- HRDATA = hrdata_s[dp_sel].
REQ-007 When dp_sel is the default slave:
- dp_act=0 (IDLE/BUSY): zero-wait OKAY.
- dp_act=1 (NONSEQ/SEQ): two-cycle ERROR via REQ-008.
- HRDATA SHALL be 0 in both cases.
REQ-008 The response FSM SHALL have states NORM, ERR1, ERR2:
- ERR1 drives HREADY=0, HRESP=1; ERR2 drives HREADY=1, HRESP=1; both override the slave mux.
- NORM->ERR1 on a default-slave active data phase or a watchdog expiry.
- ERR1->ERR2 unconditionally.
- ERR2->NORM, or ERR2->ERR1 if the newly captured data phase also requires an error.
REQ-009 Watchdog counter, width clog2(TIMEOUT+1):
- Increments each cycle in NORM with dp_act=1, dp_sel real, and hready_resp_s[dp_sel]=0.
- Clears on any HREADY=1 cycle.
- Saturates; never wraps.
REQ-010 When the counter reaches TIMEOUT (TIMEOUT>0), the block SHALL on that same clock edge:
- enter ERR1;
- set timeout_err;
- set quarantine[dp_sel].
REQ-011 A quarantined slave SHALL never be asserted on hsel_s; its address range decodes to the default slave until cleared. Its late hready_resp_s/hresp_s/hrdata_s SHALL be ignored.
REQ-012 timeout_clr=1 SHALL clear timeout_err and quarantine on the next edge. A timeout on the same edge wins: flag set, and only that slave's quarantine bit remains set.
REQ-013 TIMEOUT=0 SHALL remove all watchdog logic; timeout_err and quarantine SHALL then be tied to 0.
REQ-014 Latency: zero added wait states for real slaves. The default-slave error costs exactly one wait state.

Reset
REQ-015 On HCLK rising edge with HRESETn=0 the block SHALL set:
- dp_sel = default slave, dp_act = 0;
- FSM = NORM, counter = 0;
- timeout_err = 0, quarantine = 0.
REQ-016 Reset-time outputs SHALL be HREADY=1, HRESP=0, HRDATA=0. hsel_s SHALL follow HADDR decode combinationally.
REQ-017 Reset asserted mid-transfer, including in ERR1/ERR2, SHALL abandon the transfer with no further error cycle.

Verification
REQ-018 NONSEQ read at 0x2000_0010, slave 2 hready_resp=1, hrdata=0xCAFE_F00D -> hsel_s=4'b0100; next cycle HRDATA=0xCAFE_F00D, HREADY=1, HRESP=0.
REQ-019 With default parameters except SLV_BASE[3]=0x1000_0000 (slave 3 overlapping slave 1's range), write to 0x1000_0000 -> hsel_s=4'b0010 only.
REQ-020 Unmapped NONSEQ at 0x8000_0000 -> data phase HREADY=0, HRESP=1, then HREADY=1, HRESP=1; HRDATA=0. IDLE to the same address -> OKAY, zero wait.
REQ-021 Slave 1 holds hready_resp=0 -> after exactly 16 stall cycles, ERR1 then ERR2 are driven, timeout_err=1, quarantine=4'b0010. A later access to 0x1000_0000 gets the default-slave ERROR and hsel_s=0.
REQ-022 timeout_clr pulsed on the same edge as a slave-3 timeout -> timeout_err=1, quarantine=4'b1000.
REQ-023 Reset asserted during ERR1 -> the next cycle shows HREADY=1, HRESP=0, quarantine=0.

Source files
------------

// File: rtl/ahb_lite_nslave_ic.sv
// ---------------------------------------------------------------------------
// ahb_lite_nslave_ic
//
// Single-master AHB-Lite interconnect for NUM_SLAVES slaves. The address
// phase is decoded combinationally against per-slave base/mask pairs, and
// the master's address/control/write-data are broadcast to every slave.
// Data-phase responses are multiplexed back from the slave captured in the
// previous accepted address phase. Unmapped active transfers receive a
// two-cycle ERROR from an internal default slave. An optional watchdog
// aborts a data phase that a slave stalls for TIMEOUT cycles, answers the
// master with ERROR and isolates (quarantines) that slave until software
// clears it.
//
// Ports
//   HCLK, HRESETn          clock, synchronous active-low reset
//   HADDR..HWDATA          master address phase / write data (inputs)
//   HRDATA, HREADY, HRESP  response to master
//   hsel_s                 one-hot (or zero) slave select
//   haddr_s..hwdata_s      broadcast copies of the master signals
//   hready_s               copy of HREADY for the slaves
//   hready_resp_s, hresp_s, hrdata_s   packed per-slave responses
//   timeout_clr            pulse clearing timeout_err and quarantine
//   timeout_err            sticky watchdog flag
//   quarantine             mask of isolated slaves
// ---------------------------------------------------------------------------
module ahb_lite_nslave_ic #(
  parameter int                        NUM_SLAVES = 4,
  parameter int                        DATA_W     = 32,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = {NUM_SLAVES{32'hF000_0000}},
  parameter int                        TIMEOUT    = 16
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic                         HMASTLOCK,
  input  logic [DATA_W-1:0]            HWDATA,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [NUM_SLAVES-1:0]        hsel_s,
  output logic [31:0]                  haddr_s,
  output logic [1:0]                   htrans_s,
  output logic                         hwrite_s,
  output logic [2:0]                   hsize_s,
  output logic [2:0]                   hburst_s,
  output logic [3:0]                   hprot_s,
  output logic                         hmastlock_s,
  output logic [DATA_W-1:0]            hwdata_s,
  output logic                         hready_s,
  input  logic [NUM_SLAVES-1:0]        hready_resp_s,
  input  logic [2*NUM_SLAVES-1:0]      hresp_s,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic                         timeout_clr,
  output logic                         timeout_err,
  output logic [NUM_SLAVES-1:0]        quarantine
);

  // Index NUM_SLAVES stands for the internal default slave.
  localparam int              SEL_W   = $clog2(NUM_SLAVES + 1);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(NUM_SLAVES);
  localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    NORM = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } rsp_state_e;

  rsp_state_e          state_r;
  rsp_state_e          state_next_s;
  logic [SEL_W-1:0]    dec_sel_s;
  logic [SEL_W-1:0]    dp_sel_r;
  logic                dp_act_r;
  logic                dp_real_s;
  logic                mux_ready_s;
  logic                mux_resp_s;
  logic [DATA_W-1:0]   mux_rdata_s;
  logic                hready_int_s;
  logic                hresp_int_s;
  logic [DATA_W-1:0]   hrdata_int_s;
  logic                err_capture_s;
  logic                wd_expire_s;
  logic                terr_s;
  logic [NUM_SLAVES-1:0] quar_s;

  // Broadcast of the master address phase and write data.
  assign haddr_s     = HADDR;
  assign htrans_s    = HTRANS;
  assign hwrite_s    = HWRITE;
  assign hsize_s     = HSIZE;
  assign hburst_s    = HBURST;
  assign hprot_s     = HPROT;
  assign hmastlock_s = HMASTLOCK;
  assign hwdata_s    = HWDATA;

  // Address decode; scanning from the top down lets the lowest matching index win.
  always_comb begin
    dec_sel_s = DEF_SEL;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      dec_sel_s = (((HADDR & SLV_MASK[i*32 +: 32]) == SLV_BASE[i*32 +: 32]) && !quar_s[i])
                  ? SEL_W'(i) : dec_sel_s;
    end
  end

  // One-hot slave select derived from the decoded index.
  always_comb begin
    hsel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hsel_s[i] = (dec_sel_s == SEL_W'(i));
    end
  end

  // Data-phase target and activity, captured only when the bus advances.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_sel_r <= DEF_SEL;
      dp_act_r <= 1'b0;
    end else if (hready_int_s) begin
      dp_sel_r <= dec_sel_s;
      dp_act_r <= HTRANS[1];
    end else begin
      dp_sel_r <= dp_sel_r;
      dp_act_r <= dp_act_r;
    end
  end

  assign dp_real_s = (dp_sel_r != DEF_SEL);

  // Response multiplexer selecting the data-phase slave.
  always_comb begin
    mux_ready_s = 1'b1;
    mux_resp_s  = 1'b0;
    mux_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dp_sel_r == SEL_W'(i)) begin
        mux_ready_s = hready_resp_s[i];
        mux_resp_s  = |hresp_s[2*i +: 2];
        mux_rdata_s = hrdata_s[i*DATA_W +: DATA_W];
      end else begin
        mux_ready_s = mux_ready_s;
        mux_resp_s  = mux_resp_s;
        mux_rdata_s = mux_rdata_s;
      end
    end
  end

  // Master-facing response; the error states override the slave mux.
  always_comb begin
    hready_int_s = 1'b1;
    hresp_int_s  = 1'b0;
    hrdata_int_s = '0;
    case (state_r)
      ERR1: begin
        hready_int_s = 1'b0;
        hresp_int_s  = 1'b1;
      end
      ERR2: begin
        hready_int_s = 1'b1;
        hresp_int_s  = 1'b1;
      end
      NORM: begin
        if (dp_real_s) begin
          hready_int_s = mux_ready_s;
          hresp_int_s  = mux_resp_s;
          hrdata_int_s = mux_rdata_s;
        end else begin
          hready_int_s = 1'b1;
          hresp_int_s  = 1'b0;
          hrdata_int_s = '0;
        end
      end
      default: begin
        hready_int_s = 1'b1;
        hresp_int_s  = 1'b0;
        hrdata_int_s = '0;
      end
    endcase
  end

  assign HREADY   = hready_int_s;
  assign hready_s = hready_int_s;
  assign HRESP    = hresp_int_s;
  assign HRDATA   = hrdata_int_s;

  // An active transfer to the default slave being accepted this cycle means
  // its data phase starts in ERR1, giving exactly one wait state.
  assign err_capture_s = hready_int_s & (dec_sel_s == DEF_SEL) & HTRANS[1];

  // Response FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      NORM: begin
        if (err_capture_s || wd_expire_s) begin
          state_next_s = ERR1;
        end else begin
          state_next_s = NORM;
        end
      end
      ERR1: state_next_s = ERR2;
      ERR2: begin
        if (err_capture_s) begin
          state_next_s = ERR1;
        end else begin
          state_next_s = NORM;
        end
      end
      default: state_next_s = NORM;
    endcase
  end

  // Response FSM state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_r <= NORM;
    end else begin
      state_r <= state_next_s;
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    logic [CNT_W-1:0]      wd_cnt_r;
    logic                  stall_s;
    logic                  terr_r;
    logic [NUM_SLAVES-1:0] quar_r;
    logic [NUM_SLAVES-1:0] dp_onehot_s;

    assign stall_s     = (state_r == NORM) & dp_act_r & dp_real_s & ~mux_ready_s;
    assign wd_expire_s = stall_s & (wd_cnt_r == CNT_W'(TIMEOUT - 1));
    assign dp_onehot_s = NUM_SLAVES'(1) << dp_sel_r;

    // Stall counter: cleared whenever the bus advances, saturating at TIMEOUT.
    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        wd_cnt_r <= '0;
      end else if (hready_int_s) begin
        wd_cnt_r <= '0;
      end else if (stall_s && (wd_cnt_r != CNT_W'(TIMEOUT))) begin
        wd_cnt_r <= wd_cnt_r + CNT_W'(1);
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
    end

    // Sticky flag and quarantine mask; an expiry beats a simultaneous clear.
    always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
        terr_r <= 1'b0;
        quar_r <= '0;
      end else if (wd_expire_s) begin
        terr_r <= 1'b1;
        quar_r <= (timeout_clr ? '0 : quar_r) | dp_onehot_s;
      end else if (timeout_clr) begin
        terr_r <= 1'b0;
        quar_r <= '0;
      end else begin
        terr_r <= terr_r;
        quar_r <= quar_r;
      end
    end

    assign terr_s = terr_r;
    assign quar_s = quar_r;
  end else begin : g_no_wd
    logic unused_clr_s;
    assign unused_clr_s = timeout_clr;
    assign wd_expire_s  = 1'b0;
    assign terr_s       = 1'b0;
    assign quar_s       = '0;
  end

  assign timeout_err = terr_s;
  assign quarantine  = quar_s;

endmodule

// File: tb/tb_ahb_lite_nslave_ic.sv
// Scoreboard bench for ahb_lite_nslave_ic. The stimulus process issues one
// transfer at a time, computes the expected outcome from a transaction-level
// model (address region -> slave, quarantine mask, wait/response rules) and
// queues it; an independent monitor pops and compares whenever the DUT
// accepts an address phase or completes a data phase.
module tb_ahb_lite_nslave_ic;

  localparam int NS  = 4;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic            HMASTLOCK;
  logic [DW-1:0]   HWDATA;
  logic [DW-1:0]   HRDATA;
  logic            HREADY;
  logic            HRESP;
  logic [NS-1:0]   hsel_s;
  logic [31:0]     haddr_s;
  logic [1:0]      htrans_s;
  logic            hwrite_s;
  logic [2:0]      hsize_s;
  logic [2:0]      hburst_s;
  logic [3:0]      hprot_s;
  logic            hmastlock_s;
  logic [DW-1:0]   hwdata_s;
  logic            hready_s;
  logic [NS-1:0]   hready_resp;
  logic [2*NS-1:0] hresp;
  logic [NS*DW-1:0] hrdata;
  logic            timeout_clr;
  logic            timeout_err;
  logic [NS-1:0]   quarantine;

  // overlap-decode instance (slave 3 aliases slave 1), watchdog disabled
  logic [NS-1:0]   ovl_hsel;
  logic            ovl_terr;
  logic [NS-1:0]   ovl_quar;
  logic [DW-1:0]   ovl_unused_hrdata;
  logic            ovl_unused_hready;
  logic            ovl_unused_hresp;
  logic [31:0]     ovl_unused_haddr;
  logic [1:0]      ovl_unused_htrans;
  logic            ovl_unused_hwrite;
  logic [2:0]      ovl_unused_hsize;
  logic [2:0]      ovl_unused_hburst;
  logic [3:0]      ovl_unused_hprot;
  logic            ovl_unused_hmastlock;
  logic [DW-1:0]   ovl_unused_hwdata;
  logic            ovl_unused_hready_s;

  always #5 HCLK = ~HCLK;

  ahb_lite_nslave_ic u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .hsel_s(hsel_s), .haddr_s(haddr_s),
    .htrans_s(htrans_s), .hwrite_s(hwrite_s), .hsize_s(hsize_s), .hburst_s(hburst_s),
    .hprot_s(hprot_s), .hmastlock_s(hmastlock_s), .hwdata_s(hwdata_s), .hready_s(hready_s),
    .hready_resp_s(hready_resp), .hresp_s(hresp), .hrdata_s(hrdata),
    .timeout_clr(timeout_clr), .timeout_err(timeout_err), .quarantine(quarantine)
  );

  ahb_lite_nslave_ic #(
    .SLV_BASE({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .TIMEOUT(0)
  ) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(ovl_unused_hrdata), .HREADY(ovl_unused_hready), .HRESP(ovl_unused_hresp),
    .hsel_s(ovl_hsel), .haddr_s(ovl_unused_haddr), .htrans_s(ovl_unused_htrans),
    .hwrite_s(ovl_unused_hwrite), .hsize_s(ovl_unused_hsize), .hburst_s(ovl_unused_hburst),
    .hprot_s(ovl_unused_hprot), .hmastlock_s(ovl_unused_hmastlock),
    .hwdata_s(ovl_unused_hwdata), .hready_s(ovl_unused_hready_s),
    .hready_resp_s(hready_resp), .hresp_s(hresp), .hrdata_s(hrdata),
    .timeout_clr(timeout_clr), .timeout_err(ovl_terr), .quarantine(ovl_quar)
  );

  typedef struct {
    logic [3:0]  hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [10:0] ctl;
  } addr_exp_t;

  typedef struct {
    int          waits;
    logic        resp;
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic        terr;
    logic [3:0]  quar;
  } data_exp_t;

  addr_exp_t addr_q[$];
  data_exp_t data_q[$];

  int   total = 0;
  int   bad   = 0;
  logic issue  = 1'b0;
  logic mon_en = 1'b1;

  // reference-model state
  logic [3:0] m_quar = 4'b0;
  logic       m_terr = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Region n (address bits 31:28) belongs to slave n for n<4 unless isolated.
  function automatic int model_decode(input logic [31:0] a, input logic [3:0] q);
    int r;
    r = int'(a[31:28]);
    if (r < NS && !q[r]) return r;
    return NS;
  endfunction

  // Monitor: compares queued expectations against what the bus shows.
  initial begin
    int        w;
    bit        pend;
    addr_exp_t ae;
    data_exp_t de;
    pend = 1'b0;
    w    = 0;
    forever begin
      @(negedge HCLK);
      if (!mon_en) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (HREADY) begin
            if (data_q.size() == 0) begin
              check("data_q_underflow", 64'd1, 64'd0);
            end else begin
              de = data_q.pop_front();
              check("waits", 64'(w), 64'(de.waits));
              check("hresp", 64'(HRESP), 64'(de.resp));
              check("hrdata", 64'(HRDATA), 64'(de.rdata));
              check("hwdata_s", 64'(hwdata_s), 64'(de.wdata));
              check("hready_s", 64'(hready_s), 64'd1);
              check("timeout_err", 64'(timeout_err), 64'(de.terr));
              check("quarantine", 64'(quarantine), 64'(de.quar));
            end
            pend = 1'b0;
          end else begin
            w++;
          end
        end
        if (issue && HREADY) begin
          if (addr_q.size() == 0) begin
            check("addr_q_underflow", 64'd1, 64'd0);
          end else begin
            ae = addr_q.pop_front();
            check("hsel_s", 64'(hsel_s), 64'(ae.hsel));
            check("haddr_s", 64'(haddr_s), 64'(ae.haddr));
            check("htrans_s", 64'(htrans_s), 64'(ae.htrans));
            check("hwrite_s", 64'(hwrite_s), 64'(ae.hwrite));
            check("ctl_s", 64'({hsize_s, hburst_s, hprot_s, hmastlock_s}), 64'(ae.ctl));
          end
          pend = 1'b1;
          w    = 0;
        end
      end
    end
  end

  // One non-pipelined transfer. w = stall cycles the addressed slave inserts;
  // clr_at >= 0 raises timeout_clr so the edge ending stall cycle clr_at+1 sees it.
  task automatic xfer(input logic [31:0] addr, input logic [1:0] trans, input int w,
                      input int clr_at, input logic [31:0] rd_val, input logic [1:0] rsp);
    int        raw;
    int        tgt;
    int        cnt;
    bit        done;
    logic      wr;
    logic [31:0] wd;
    logic [10:0] ctl;
    addr_exp_t ae;
    data_exp_t de;
    raw = int'(addr[31:28]) < NS ? int'(addr[31:28]) : NS;
    tgt = model_decode(addr, m_quar);
    wr  = 1'($urandom_range(0, 1));
    wd  = $urandom;
    ctl = {3'b010, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1))};
    @(posedge HCLK); #1;
    for (int i = 0; i < NS; i++) begin
      hrdata[i*DW +: DW] = $urandom;
      hresp[2*i +: 2]    = 2'($urandom_range(0, 3));
    end
    hready_resp = '1;
    timeout_clr = 1'b0;
    if (raw < NS) begin
      hrdata[raw*DW +: DW] = rd_val;
      hresp[2*raw +: 2]    = rsp;
    end
    HADDR = addr; HTRANS = trans; HWRITE = wr;
    {HSIZE, HBURST, HPROT, HMASTLOCK} = ctl;
    ae.hsel = (tgt < NS) ? 4'(1 << tgt) : 4'b0000;
    ae.haddr = addr; ae.htrans = trans; ae.hwrite = wr; ae.ctl = ctl;
    de.wdata = wd;
    if (tgt == NS) begin
      de.waits = trans[1] ? 1 : 0;
      de.resp  = trans[1];
      de.rdata = 32'h0;
    end else if (trans[1] && w >= TMO) begin
      de.waits = TMO + 1;
      de.resp  = 1'b1;
      de.rdata = 32'h0;
      m_terr   = 1'b1;
      m_quar   = ((clr_at >= 0) ? 4'b0000 : m_quar) | 4'(1 << tgt);
    end else begin
      de.waits = w;
      de.resp  = |rsp;
      de.rdata = rd_val;
    end
    de.terr = m_terr;
    de.quar = m_quar;
    addr_q.push_back(ae);
    data_q.push_back(de);
    issue = 1'b1;
    @(posedge HCLK); #1;
    issue  = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wd;
    cnt    = 0;
    if (raw < NS) hready_resp[raw] = (w == 0);
    timeout_clr = (clr_at == 0);
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge HCLK);
      if (HREADY) begin
        done = 1'b1;
      end else begin
        @(posedge HCLK); #1;
        cnt++;
        if (raw < NS) hready_resp[raw] = (cnt >= w);
        timeout_clr = (cnt == clr_at);
      end
    end
    if (!done) check("stall_bound", 64'd0, 64'd1);
  endtask

  task automatic clr_pulse();
    @(posedge HCLK); #1;
    timeout_clr = 1'b1;
    @(posedge HCLK); #1;
    timeout_clr = 1'b0;
    m_quar = 4'b0000;
    m_terr = 1'b0;
  endtask

  // Stop a hung run with a visible failure.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang, want completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [3:0]  rr;
    logic [1:0]  tr;
    logic [1:0]  rs;
    int          w;
    HRESETn = 1'b0; HADDR = 32'h2000_0000; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'b0011; HMASTLOCK = 1'b0; HWDATA = '0;
    hready_resp = '1; hresp = '0; hrdata = '0; timeout_clr = 1'b0;

    // reset state
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hready", 64'(HREADY), 64'd1);
    check("rst_hresp", 64'(HRESP), 64'd0);
    check("rst_hrdata", 64'(HRDATA), 64'd0);
    check("rst_hsel", 64'(hsel_s), 64'b0100);
    check("rst_terr", 64'(timeout_err), 64'd0);
    check("rst_quar", 64'(quarantine), 64'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // overlapping decode: lowest index wins; no watchdog means tied status
    HADDR = 32'h1000_0000; HWRITE = 1'b1;
    @(negedge HCLK);
    check("ovl_hsel_1", 64'(ovl_hsel), 64'b0010);
    check("ovl_terr", 64'(ovl_terr), 64'd0);
    check("ovl_quar", 64'(ovl_quar), 64'd0);
    @(posedge HCLK); #1;
    HADDR = 32'h3000_0040;
    @(negedge HCLK);
    check("ovl_hsel_3", 64'(ovl_hsel), 64'b0000);

    // directed scenarios
    xfer(32'h2000_0010, 2'b10, 0, -1, 32'hCAFE_F00D, 2'b00);   // slave 2 read
    xfer(32'h8000_0000, 2'b10, 0, -1, 32'h1234_5678, 2'b00);   // unmapped active
    xfer(32'h8000_0000, 2'b00, 0, -1, 32'h1234_5678, 2'b00);   // unmapped idle
    xfer(32'h0000_0100, 2'b11, 2, -1, 32'h0BAD_BEEF, 2'b01);   // slave 0, waits, error
    xfer(32'h1000_0000, 2'b10, 20, -1, 32'h5555_AAAA, 2'b00);  // slave 1 timeout
    xfer(32'h1000_0000, 2'b10, 0, -1, 32'h7777_0000, 2'b00);   // now default error
    xfer(32'h3000_0000, 2'b10, 20, 15, 32'h3333_3333, 2'b00);  // clear on expiry edge
    clr_pulse();
    xfer(32'h1000_0020, 2'b10, 3, -1, 32'hA5A5_5A5A, 2'b00);   // slave 1 restored

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      rr = 4'($urandom_range(0, 7));
      tr = 2'($urandom_range(0, 3));
      rs = tr[1] ? (($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00) : 2'b00;
      w  = 0;
      if (tr[1] && rr < 4'd4) w = ($urandom_range(0, 11) == 0) ? 20 : $urandom_range(0, 3);
      xfer({rr, 28'($urandom) & 28'hFFF_FFFC}, tr, w, -1, $urandom, rs);
      if ($urandom_range(0, 9) == 0) clr_pulse();
    end

    // back-to-back default-slave errors: ERR2 hands straight to ERR1
    @(posedge HCLK); #1;
    mon_en = 1'b0; hready_resp = '1;
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HADDR = 32'h9000_0000;
    @(negedge HCLK);
    check("b2b_err1a", 64'({HREADY, HRESP}), 64'b01);
    @(negedge HCLK);
    check("b2b_err2a", 64'({HREADY, HRESP}), 64'b11);
    @(posedge HCLK); #1;
    HTRANS = 2'b00;
    @(negedge HCLK);
    check("b2b_err1b", 64'({HREADY, HRESP}), 64'b01);
    @(negedge HCLK);
    check("b2b_err2b", 64'({HREADY, HRESP}), 64'b11);
    @(negedge HCLK);
    check("b2b_idle", 64'({HREADY, HRESP}), 64'b10);
    @(posedge HCLK); #1;
    mon_en = 1'b1;

    // reset during ERR1 with a slave quarantined
    xfer(32'h2000_0000, 2'b10, 20, -1, 32'h2222_2222, 2'b00);
    @(posedge HCLK); #1;
    mon_en = 1'b0; hready_resp = '1;
    HADDR = 32'h8000_0000; HTRANS = 2'b10;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst_in_err1_pre", 64'(HREADY), 64'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    m_quar = 4'b0000; m_terr = 1'b0;
    @(negedge HCLK);
    check("rst_err1_hready", 64'(HREADY), 64'd1);
    check("rst_err1_hresp", 64'(HRESP), 64'd0);
    check("rst_err1_quar", 64'(quarantine), 64'd0);
    check("rst_err1_terr", 64'(timeout_err), 64'd0);
    @(negedge HCLK);
    check("rst_err1_no_err2", 64'({HREADY, HRESP}), 64'b10);
    @(posedge HCLK); #1;
    mon_en = 1'b1;
    xfer(32'h2000_0008, 2'b10, 1, -1, 32'h600D_CAFE, 2'b00);   // slave 2 back in service

    repeat (3) @(posedge HCLK);
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    check("data_q_drained", 64'(data_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
